// File: rtl/if_byte_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four byte
// reads on the 8-bit memory port and hands the word to IF/ID in memory byte order.
module if_byte_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] stall,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              mem_busy,
    input  logic [7:0]        mem_din,
    output logic              mem_rd_en,
    output logic [31:0]       mem_a,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic              stallreq_if
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  recv_cnt_q, recv_cnt_d;
    logic        pend_q, pend_d;

    logic        word_done;
    logic        consume;
    logic        hold_ifid;
    logic        unused_stall_bits;

    // Only the IF/ID hold bit matters here; the rest of the bus is folded away.
    assign unused_stall_bits = ^stall;
    assign hold_ifid         = stall[1];

    assign word_done = (recv_cnt_q == 3'd4);
    assign consume   = word_done && !hold_ifid;

    assign mem_rd_en   = !rst && !branch_flag && (issue_cnt_q < 3'd4) && !mem_busy;
    assign mem_a       = pc_q + {29'd0, issue_cnt_q};
    assign if_pc       = pc_q;
    assign if_inst     = inst_buf_q;
    assign stallreq_if = !word_done;

    // A redirect wipes any in-flight fetch; the byte still returning next
    // cycle is dropped because pend is cleared here.
    always_comb begin
        pc_d        = pc_q;
        inst_buf_d  = inst_buf_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pend_d      = 1'b0;

        if (branch_flag) begin
            pc_d        = branch_target;
            inst_buf_d  = 32'd0;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
        end else if (consume) begin
            pc_d        = pc_q + 32'd4;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
        end else begin
            if (mem_rd_en) begin
                issue_cnt_d = issue_cnt_q + 3'd1;
                pend_d      = 1'b1;
            end
            if (pend_q && !word_done) begin
                case (recv_cnt_q[1:0])
                    2'd0:    inst_buf_d[31:24] = mem_din;
                    2'd1:    inst_buf_d[23:16] = mem_din;
                    2'd2:    inst_buf_d[15:8]  = mem_din;
                    default: inst_buf_d[7:0]   = mem_din;
                endcase
                recv_cnt_d = recv_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            inst_buf_q  <= 32'd0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            pend_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            inst_buf_q  <= inst_buf_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pend_q      <= pend_d;
        end
    end

endmodule
